// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: packs instruction field tuples into 32-bit words and
// streams them into instruction memory from a programmable base address,
// through a 2-entry buffer with valid/ready handshakes on both sides.
// Optional macro INST_ENC_CHECK_EN adds a sticky field_err output that flags
// tuples whose fields cannot all be represented in the chosen format.
module inst_encoder_loader #(
    parameter int INST_WIDTH = 32,
    parameter int REG_WIDTH  = 4,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op1,
    input  logic [3:0]            op2,
    input  logic [REG_WIDTH-1:0]  rd,
    input  logic [REG_WIDTH-1:0]  rs1,
    input  logic [REG_WIDTH-1:0]  rs2,
    input  logic                  use_rs2,
    input  logic [15:0]           imm16,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [INST_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   word_count
`ifdef INST_ENC_CHECK_EN
    ,
    output logic                  field_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = 1;

    state_t                r_state;
    state_t                w_stateNext;
    logic [INST_WIDTH-1:0] r_mem [0:1];
    logic                  r_rdPtr;
    logic                  r_wrPtr;
    logic [1:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_wrAddr;
    logic [ADDR_WIDTH-1:0] r_issueAddr;
    logic                  r_lastIssued;
    logic                  r_full;
    logic [ADDR_WIDTH:0]   r_wordCount;
    logic [INST_WIDTH-1:0] w_encoded;
    logic                  w_accept;
    logic                  w_transfer;
    logic                  w_startSession;
    logic                  w_done;

    // Pack the current tuple using the decoder's field layout for its format.
    always_comb begin
        w_encoded = '0;
        if (op1[2]) begin
            w_encoded = {op1, op2, rs1, rs2, imm16};
        end else if (use_rs2) begin
            w_encoded = {op1, op2, rd, rs1, rs2, 12'h000};
        end else begin
            w_encoded = {op1, op2, rd, rs1, imm16};
        end
    end

    assign in_ready       = (r_state == S_RUN) && (r_count != 2'd2) && !r_lastIssued;
    assign wr_valid       = (r_count != 2'd0) && (r_state != S_IDLE);
    assign w_accept       = in_valid && in_ready;
    assign w_transfer     = wr_valid && wr_ready;
    assign w_startSession = (r_state == S_IDLE) && start;

    assign wr_data    = r_mem[r_rdPtr];
    assign wr_addr    = r_wrAddr;
    assign busy       = (r_state != S_IDLE);
    assign done       = w_done;
    assign full       = r_full;
    assign word_count = r_wordCount;

    // Session state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; stop wins over start, and done fires as DRAIN empties.
    always_comb begin
        w_stateNext = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_stateNext = S_DRAIN;
                end else if (w_transfer && (r_wrAddr == LAST_ADDR)) begin
                    w_stateNext = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_count == 2'd0) begin
                    w_stateNext = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Two-entry buffer; occupancy changes only on an unmatched push or pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_accept) begin
                r_mem[r_wrPtr] <= w_encoded;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_transfer) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_accept, w_transfer})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Address and count tracking; neither address counter wraps past all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrAddr     <= '0;
            r_issueAddr  <= '0;
            r_lastIssued <= 1'b0;
            r_full       <= 1'b0;
            r_wordCount  <= '0;
        end else if (w_startSession) begin
            r_wrAddr     <= base_addr;
            r_issueAddr  <= base_addr;
            r_lastIssued <= 1'b0;
            r_full       <= 1'b0;
            r_wordCount  <= '0;
        end else begin
            if (w_accept) begin
                if (r_issueAddr == LAST_ADDR) begin
                    r_lastIssued <= 1'b1;
                end else begin
                    r_issueAddr <= r_issueAddr + ADDR_ONE;
                end
            end
            if (w_transfer) begin
                r_wordCount <= r_wordCount + COUNT_ONE;
                if (r_wrAddr == LAST_ADDR) begin
                    r_full <= 1'b1;
                end else begin
                    r_wrAddr <= r_wrAddr + ADDR_ONE;
                end
            end
        end
    end

`ifdef INST_ENC_CHECK_EN
    logic r_fieldErr;
    logic w_fieldLoss;

    assign w_fieldLoss = (!op1[2] && use_rs2 && (imm16[11:0] != 12'h000)) ||
                         (op1[2] && (rd != rs1));
    assign field_err   = r_fieldErr;

    // Sticky flag for accepted tuples that carried bits the format drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fieldErr <= 1'b0;
        end else if (w_startSession) begin
            r_fieldErr <= 1'b0;
        end else if (w_accept && w_fieldLoss) begin
            r_fieldErr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Testbench for inst_encoder_loader: drives tuples and imem backpressure,
// predicts every output from a queue-based model of the loader's behaviour.
module tb_inst_encoder_loader;

    typedef struct packed {
        logic [3:0]  op1;
        logic [3:0]  op2;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        useRs2;
        logic [15:0] imm16;
    } tuple_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        use_rs2;
    logic [15:0] imm16;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        full;
    logic [10:0] word_count;
`ifdef INST_ENC_CHECK_EN
    logic        field_err;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: pending tuples, words buffered in the loader, session facts.
    tuple_t      offerQ[$];
    logic [31:0] expQ[$];
    int          mState;
    logic [9:0]  mWrAddr;
    logic [9:0]  mIssue;
    bit          mLast;
    bit          mFull;
    logic [10:0] mWc;
    bit          mFieldErr;
    int          cycleNum;
    int          lastXferCycle;
    int          doneCycle;
    bit          sawDone;

    inst_encoder_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op1        (op1),
        .op2        (op2),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .use_rs2    (use_rs2),
        .imm16      (imm16),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .full       (full),
        .word_count (word_count)
`ifdef INST_ENC_CHECK_EN
        ,
        .field_err  (field_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] modelEncode(input tuple_t t);
        if (t.op1[2]) return {t.op1, t.op2, t.rs1, t.rs2, t.imm16};
        if (t.useRs2) return {t.op1, t.op2, t.rd, t.rs1, t.rs2, 12'h000};
        return {t.op1, t.op2, t.rd, t.rs1, t.imm16};
    endfunction

    function automatic tuple_t randTuple();
        tuple_t t;
        t.op1    = 4'($urandom);
        t.op2    = 4'($urandom);
        t.rd     = 4'($urandom);
        t.rs1    = 4'($urandom);
        t.rs2    = 4'($urandom);
        t.useRs2 = 1'($urandom);
        t.imm16  = 16'($urandom);
        return t;
    endfunction

    function automatic tuple_t mkTuple(input logic [3:0] o1, input logic [3:0] o2,
                                       input logic [3:0] d, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic u,
                                       input logic [15:0] imm);
        tuple_t t;
        t.op1 = o1; t.op2 = o2; t.rd = d; t.rs1 = s1; t.rs2 = s2;
        t.useRs2 = u; t.imm16 = imm;
        return t;
    endfunction

    task automatic modelReset();
        mState = 0; expQ.delete(); offerQ.delete();
        mWrAddr = '0; mIssue = '0; mLast = 0; mFull = 0; mWc = '0; mFieldErr = 0;
    endtask

    // One clock of stimulus: present the head of offerQ, compare every output
    // against the model at the falling edge, then advance the model.
    task automatic applyStimulus(input bit validEn, input bit wrRdy, input bit stp,
                                 input bit strt, input logic [9:0] base);
        tuple_t t;
        bit offering, expInReady, expWrValid, expDone, xfer, acc;
        int nextState;
        offering = validEn && (offerQ.size() > 0);
        t = offering ? offerQ[0] : randTuple();
        in_valid = offering; op1 = t.op1; op2 = t.op2; rd = t.rd; rs1 = t.rs1;
        rs2 = t.rs2; use_rs2 = t.useRs2; imm16 = t.imm16;
        wr_ready = wrRdy; stop = stp; start = strt; base_addr = base;
        @(negedge clk);
        expInReady = (mState == 1) && (expQ.size() < 2) && !mLast;
        expWrValid = (mState != 0) && (expQ.size() > 0);
        expDone    = (mState == 2) && (expQ.size() == 0);
        checks++; if (in_ready !== expInReady) begin errors++;
            $display("[TB] FAIL in_ready: got %b expected %b (cycle %0d)", in_ready, expInReady, cycleNum); end
        checks++; if (wr_valid !== expWrValid) begin errors++;
            $display("[TB] FAIL wr_valid: got %b expected %b (cycle %0d)", wr_valid, expWrValid, cycleNum); end
        checks++; if (busy !== (mState != 0)) begin errors++;
            $display("[TB] FAIL busy: got %b expected %b (cycle %0d)", busy, (mState != 0), cycleNum); end
        checks++; if (done !== expDone) begin errors++;
            $display("[TB] FAIL done: got %b expected %b (cycle %0d)", done, expDone, cycleNum); end
        checks++; if (full !== mFull) begin errors++;
            $display("[TB] FAIL full: got %b expected %b (cycle %0d)", full, mFull, cycleNum); end
        checks++; if (word_count !== mWc) begin errors++;
            $display("[TB] FAIL word_count: got %0d expected %0d (cycle %0d)", word_count, mWc, cycleNum); end
`ifdef INST_ENC_CHECK_EN
        checks++; if (field_err !== mFieldErr) begin errors++;
            $display("[TB] FAIL field_err: got %b expected %b (cycle %0d)", field_err, mFieldErr, cycleNum); end
`endif
        if (done === 1'b1) begin sawDone = 1; doneCycle = cycleNum; end
        xfer = expWrValid && wrRdy;
        acc  = offering && expInReady;
        if (xfer) begin
            lastXferCycle = cycleNum;
            checks++; if (wr_data !== expQ[0]) begin errors++;
                $display("[TB] FAIL wr_data: got %h expected %h (cycle %0d)", wr_data, expQ[0], cycleNum); end
            checks++; if (wr_addr !== mWrAddr) begin errors++;
                $display("[TB] FAIL wr_addr: got %h expected %h (cycle %0d)", wr_addr, mWrAddr, cycleNum); end
        end
        if (mState == 0) begin
            if (strt) begin
                mState = 1; mWrAddr = base; mIssue = base; mWc = '0;
                mFull = 0; mLast = 0; mFieldErr = 0;
            end
        end else begin
            nextState = mState;
            if (mState == 1 && (stp || (xfer && mWrAddr == 10'h3FF))) nextState = 2;
            if (mState == 2 && expQ.size() == 0) nextState = 0;
            if (xfer) begin
                void'(expQ.pop_front());
                mWc = mWc + 11'd1;
                if (mWrAddr == 10'h3FF) mFull = 1; else mWrAddr = mWrAddr + 10'd1;
            end
            if (acc) begin
                expQ.push_back(modelEncode(t));
                void'(offerQ.pop_front());
                if (mIssue == 10'h3FF) mLast = 1; else mIssue = mIssue + 10'd1;
                if ((!t.op1[2] && t.useRs2 && t.imm16[11:0] != 12'h000) ||
                    (t.op1[2] && t.rd != t.rs1)) mFieldErr = 1;
            end
            mState = nextState;
        end
        @(posedge clk);
        #1;
        cycleNum++;
    endtask

    // Pulse stop and drain until the DUT reports idle, bounded.
    task automatic endSession();
        applyStimulus(0, 1, 1, 0, '0);
        for (int i = 0; i < 30 && busy !== 1'b0; i++) applyStimulus(0, 1, 0, 0, '0);
        checks++; if (busy !== 1'b0) begin errors++;
            $display("[TB] FAIL drain_timeout: busy got %b expected 0", busy); end
        offerQ.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 0; stop = 0; in_valid = 0; wr_ready = 0;
        base_addr = '0; op1 = '0; op2 = '0; rd = '0; rs1 = '0; rs2 = '0;
        use_rs2 = 0; imm16 = '0;
        modelReset(); cycleNum = 0; sawDone = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({in_ready, wr_valid, busy, done, full} !== 5'b0) begin errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {in_ready, wr_valid, busy, done, full}); end
        checks++; if (wr_addr !== 10'h000 || word_count !== 11'h000) begin errors++;
            $display("[TB] FAIL reset_counts: got addr=%h wc=%0d expected 0/0", wr_addr, word_count); end
        checks++; if (wr_data !== 32'h0) begin errors++;
            $display("[TB] FAIL reset_data: got %h expected 00000000", wr_data); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_encode();
        applyStimulus(0, 1, 0, 1, 10'h010);
        offerQ.push_back(mkTuple(4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 1'b1, 16'h0000));
        offerQ.push_back(mkTuple(4'b0100, 4'd2, 4'd0, 4'd6, 4'd7, 1'b0, 16'h0010));
        offerQ.push_back(mkTuple(4'd1, 4'd0, 4'd2, 4'd3, 4'd0, 1'b0, 16'hBEEF));
        applyStimulus(1, 1, 0, 0, '0);
        checks++; if (wr_valid !== 1'b1 || wr_data !== 32'h01345000 || wr_addr !== 10'h010) begin errors++;
            $display("[TB] FAIL enc_rrr: got v=%b %h@%h expected 1 01345000@010", wr_valid, wr_data, wr_addr); end
        applyStimulus(1, 1, 0, 0, '0);
        checks++; if (word_count !== 11'd1 || wr_data !== 32'h42670010 || wr_addr !== 10'h011) begin errors++;
            $display("[TB] FAIL enc_branch: got wc=%0d %h@%h expected 1 42670010@011", word_count, wr_data, wr_addr); end
        applyStimulus(1, 1, 0, 0, '0);
        checks++; if (wr_data !== 32'h1023BEEF || wr_addr !== 10'h012) begin errors++;
            $display("[TB] FAIL enc_imm: got %h@%h expected 1023BEEF@012", wr_data, wr_addr); end
        applyStimulus(1, 1, 0, 0, '0);
        endSession();
        checks++; if (word_count !== 11'd3) begin errors++;
            $display("[TB] FAIL enc_count: got %0d expected 3", word_count); end
    endtask

    task automatic test_backpressure();
        tuple_t first;
        applyStimulus(0, 0, 0, 1, 10'h080);
        first = randTuple();
        offerQ.push_back(first);
        offerQ.push_back(randTuple());
        offerQ.push_back(randTuple());
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, '0);
            if (i >= 1) begin
                checks++; if (wr_data !== modelEncode(first) || wr_addr !== 10'h080) begin errors++;
                    $display("[TB] FAIL bp_stable: got %h@%h expected %h@080", wr_data, wr_addr, modelEncode(first)); end
            end
        end
        checks++; if (in_ready !== 1'b0 || offerQ.size() != 1) begin errors++;
            $display("[TB] FAIL bp_hold: in_ready got %b expected 0, pending %0d expected 1", in_ready, offerQ.size()); end
        for (int i = 0; i < 20 && (offerQ.size() > 0 || expQ.size() > 0); i++) applyStimulus(1, 1, 0, 0, '0);
        checks++; if (word_count !== 11'd3 || wr_addr !== 10'h083) begin errors++;
            $display("[TB] FAIL bp_release: got wc=%0d addr=%h expected 3/083", word_count, wr_addr); end
        endSession();
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            int n;
            n = 12 + int'($urandom_range(13, 0));
            applyStimulus(0, 1, 0, 1, 10'($urandom_range(10'h300, 0)));
            for (int i = 0; i < n; i++) offerQ.push_back(randTuple());
            for (int i = 0; i < 400 && (offerQ.size() > 0 || expQ.size() > 0); i++)
                applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0, 0, 0, '0);
            checks++; if (offerQ.size() != 0 || expQ.size() != 0) begin errors++;
                $display("[TB] FAIL rand_timeout: pending %0d buffered %0d expected 0/0", offerQ.size(), expQ.size()); end
            endSession();
            checks++; if (word_count !== 11'(n)) begin errors++;
                $display("[TB] FAIL rand_count: got %0d expected %0d", word_count, n); end
        end
    endtask

    task automatic test_end_of_memory();
        sawDone = 0;
        applyStimulus(0, 1, 0, 1, 10'h3FE);
        for (int i = 0; i < 4; i++) offerQ.push_back(randTuple());
        applyStimulus(1, 1, 0, 0, '0);
        for (int i = 0; i < 20 && busy !== 1'b0; i++) applyStimulus(1, 1, 0, 0, '0);
        checks++; if (offerQ.size() != 2 || word_count !== 11'd2) begin errors++;
            $display("[TB] FAIL eom_count: pending %0d wc %0d expected 2/2", offerQ.size(), word_count); end
        checks++; if (full !== 1'b1 || busy !== 1'b0 || sawDone != 1) begin errors++;
            $display("[TB] FAIL eom_flags: full=%b busy=%b done_seen=%0d expected 1/0/1", full, busy, sawDone); end
        offerQ.delete();
    endtask

    task automatic test_stop_drain();
        sawDone = 0;
        applyStimulus(0, 0, 0, 1, 10'h100);
        for (int i = 0; i < 3; i++) offerQ.push_back(randTuple());
        applyStimulus(1, 0, 0, 0, '0);
        applyStimulus(1, 0, 0, 0, '0);
        applyStimulus(1, 0, 1, 1, 10'h3AA);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("[TB] FAIL stop_ready: in_ready=%b busy=%b expected 0/1", in_ready, busy); end
        for (int i = 0; i < 10 && busy !== 1'b0; i++) applyStimulus(1, 1, 0, 0, '0);
        checks++; if (word_count !== 11'd2 || wr_addr !== 10'h102 || offerQ.size() != 1) begin errors++;
            $display("[TB] FAIL stop_words: wc=%0d addr=%h pending %0d expected 2/102/1", word_count, wr_addr, offerQ.size()); end
        checks++; if (sawDone != 1 || doneCycle != lastXferCycle + 1) begin errors++;
            $display("[TB] FAIL stop_done: done cycle %0d expected %0d", doneCycle, lastXferCycle + 1); end
        offerQ.delete();
    endtask

    task automatic test_reset_mid();
        applyStimulus(0, 0, 0, 1, 10'h200);
        offerQ.push_back(randTuple());
        offerQ.push_back(randTuple());
        applyStimulus(1, 0, 0, 0, '0);
        applyStimulus(1, 0, 0, 0, '0);
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({in_ready, wr_valid, busy, done, full} !== 5'b0 || word_count !== 11'd0 ||
                      wr_addr !== 10'h0 || wr_data !== 32'h0) begin errors++;
            $display("[TB] FAIL mid_reset: flags %b wc %0d %h@%h expected all zero",
                     {in_ready, wr_valid, busy, done, full}, word_count, wr_data, wr_addr); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("[TB] FAIL mid_reset_done: done=%b busy=%b expected 0/0", done, busy); end
        reset_n = 1'b1;
        modelReset();
        applyStimulus(0, 1, 0, 0, '0);
        applyStimulus(0, 1, 0, 0, '0);
    endtask

`ifdef INST_ENC_CHECK_EN
    task automatic test_field_err();
        applyStimulus(0, 1, 0, 1, 10'h040);
        offerQ.push_back(mkTuple(4'd0, 4'd3, 4'd1, 4'd2, 4'd3, 1'b1, 16'h0001));
        offerQ.push_back(mkTuple(4'd1, 4'd0, 4'd2, 4'd3, 4'd0, 1'b0, 16'h1234));
        offerQ.push_back(mkTuple(4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 1'b1, 16'h0000));
        for (int i = 0; i < 10 && (offerQ.size() > 0 || expQ.size() > 0); i++) applyStimulus(1, 1, 0, 0, '0);
        checks++; if (field_err !== 1'b1) begin errors++;
            $display("[TB] FAIL ferr_set: got %b expected 1", field_err); end
        endSession();
        checks++; if (field_err !== 1'b1) begin errors++;
            $display("[TB] FAIL ferr_sticky: got %b expected 1", field_err); end
        applyStimulus(0, 1, 0, 1, 10'h050);
        checks++; if (field_err !== 1'b0) begin errors++;
            $display("[TB] FAIL ferr_clear: got %b expected 0", field_err); end
        endSession();
    endtask
`endif

    initial begin
        test_reset();
        test_encode();
        test_backpressure();
        test_random();
        test_end_of_memory();
        test_stop_drain();
        test_reset_mid();
`ifdef INST_ENC_CHECK_EN
        test_field_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Packs instruction fields (op1, op2, rd, rs1, rs2, imm16) into 32-bit instruction words, using the same bit layout the core's instruction decoder extracts.
- Writes the words sequentially into instruction memory from a programmable base address.
- Sits between the test/boot loader front end and the imem write port.
- Provides a 2-entry output buffer, valid/ready on both sides, and a run/drain state machine.

Parameters:
- INST_WIDTH, 32, instruction word width (layout below fixed for 32).
- REG_WIDTH, 4, register specifier width.
- ADDR_WIDTH, 10, imem word-address width.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse; load base_addr, begin session
- stop  in  1  pulse; end session after draining buffer
- base_addr  in  ADDR_WIDTH  first imem address of session
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder accepts tuple
- op1  in  4  primary opcode
- op2  in  4  secondary opcode
- rd  in  REG_WIDTH  destination register
- rs1  in  REG_WIDTH  source register 1
- rs2  in  REG_WIDTH  source register 2
- use_rs2  in  1  non-branch format: 1 = rs2 in [15:12], 0 = imm16 in [15:0]
- imm16  in  16  immediate
- wr_valid  out  1  imem write request
- wr_ready  in  1  imem accepts write
- wr_addr  out  ADDR_WIDTH  imem word address
- wr_data  out  INST_WIDTH  encoded instruction
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on return to IDLE
- full  out  1  sticky; last address (all ones) written this session
- word_count  out  ADDR_WIDTH+1  words written this session

Behaviour:
- Encoding, combinational on the input tuple:
  - [31:28] = op1, [27:24] = op2.
  - If op1[2]=1 (branch/store class): [23:20] = rs1, [19:16] = rs2, [15:0] = imm16; rd ignored.
  - If op1[2]=0 and use_rs2=1: [23:20] = rd, [19:16] = rs1, [15:12] = rs2, [11:0] = 0.
  - If op1[2]=0 and use_rs2=0: [23:20] = rd, [19:16] = rs1, [15:0] = imm16; rs2 ignored.
- Reset: state IDLE, buffer empty, all counters 0, every output 0 (in_ready, wr_valid, wr_addr, wr_data, busy, done, full, word_count).
- States: IDLE, RUN, DRAIN.
  - IDLE: start moves to RUN and loads wr-address counter and issue counter with base_addr, word_count = 0, full = 0, last_issued = 0.
  - RUN: stop moves to DRAIN. stop and start in the same cycle: start ignored, stop honoured.
  - RUN: a write to address all-ones moves to DRAIN.
  - DRAIN: buffer empty moves to IDLE with done=1 for one cycle.
  - start outside IDLE is ignored.
- in_ready = (state==RUN) && buffer not full && !last_issued.
- Accept occurs when in_valid && in_ready. The encoded word is pushed into the 2-entry FIFO and the issue counter increments. Accept at issue address all-ones sets last_issued (no wrap).
- Latency: a word accepted in cycle N appears on wr_data/wr_valid in cycle N+1 at the earliest.
- wr_valid = buffer non-empty, in RUN or DRAIN. wr_data and wr_addr are held stable while wr_valid && !wr_ready.
- Transfer occurs when wr_valid && wr_ready: pop FIFO, increment wr_addr and word_count. A transfer at address all-ones sets full.
- Push and pop in the same cycle with buffer at 1 entry: occupancy stays 1.
- Buffer full: in_ready=0 until a pop. The push/pop decision uses the registered occupancy.
- word_count reaches 2^ADDR_WIDTH with base_addr=0.
- Reset mid-session: buffered words are discarded, return to IDLE, no done pulse.

Optional Feature:
- Macro INST_ENC_CHECK_EN.
- Defined:
  - Adds output field_err (1 bit, sticky, cleared by start, reset 0).
  - Set on accept when op1[2]=0, use_rs2=1 and imm16[11:0]!=0 (immediate bits lost).
  - Set on accept when op1[2]=1 and rd!=rs1 (rd silently dropped).
  - Encoding is unchanged.
- Undefined: field_err port and checking logic are absent.

Test Plan:
- Reset, then start with base_addr=0x010; tuple op1=0, op2=1, rd=3, rs1=4, rs2=5, use_rs2=1 -> wr_data=0x01345000 at wr_addr=0x010 one cycle after accept; word_count=1.
- Tuple op1=4'b0100, op2=2, rs1=6, rs2=7, imm16=0x0010 -> 0x42670010. Tuple op1=1, op2=0, rd=2, rs1=3, use_rs2=0, imm16=0xBEEF -> 0x1023BEEF.
- Hold wr_ready=0 with 3 tuples offered -> 2 accepted, in_ready=0, wr_data/wr_addr stable. Release wr_ready -> 3 writes at consecutive addresses, in order.
- base_addr=0x3FE, 4 tuples offered -> only 2 accepted; writes to 0x3FE and 0x3FF; full=1; done pulse; busy=0.
- stop with 2 words buffered -> in_ready=0 immediately; both words written; done one cycle after the last transfer. Assert reset_n mid-burst -> all outputs 0, no done.
- With INST_ENC_CHECK_EN: op1=0, use_rs2=1, imm16=0x0001 -> field_err=1, held through later clean tuples, cleared by next start.
